// File: rtl/bch_link_sequencer.sv
// Frame sequencer for the BCH link datapath: walks encode -> noise -> errors -> decode,
// skips disabled stages, times out stalled stages and reports completion or fault.
module bch_link_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_bch_en,
    input  logic             cfg_noise_en,
    input  logic             cfg_err_en,
    input  logic [7:0]       cfg_num_errors,
    output logic             enc_start,
    input  logic             enc_done,
    output logic             noise_start,
    input  logic             noise_done,
    output logic             err_start,
    output logic [7:0]       err_count,
    input  logic             err_done,
    output logic             dec_start,
    input  logic             dec_done,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [2:0]       fault_stage,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] frame_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENCODE   = 3'd1,
        ST_NOISE    = 3'd2,
        ST_ERRORS   = 3'd3,
        ST_DECODE   = 3'd4,
        ST_FINISHED = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 32'sd1);

    state_t           state_r;
    state_t           state_nx_s;
    logic             bch_en_r;
    logic             noise_en_r;
    logic             err_en_r;
    logic [CNT_W-1:0] tcnt_r;
    logic             accept_s;
    logic             stage_done_s;
    logic             timeout_s;

    // First enabled stage after cur; decode shares the bch enable with encode.
    function automatic state_t next_stage(input state_t cur, input logic bch,
                                          input logic noise, input logic err);
        state_t nx;
        nx = ST_FINISHED;
        case (cur)
            ST_IDLE: begin
                if (bch)        nx = ST_ENCODE;
                else if (noise) nx = ST_NOISE;
                else if (err)   nx = ST_ERRORS;
                else            nx = ST_FINISHED;
            end
            ST_ENCODE: begin
                if (noise)      nx = ST_NOISE;
                else if (err)   nx = ST_ERRORS;
                else if (bch)   nx = ST_DECODE;
                else            nx = ST_FINISHED;
            end
            ST_NOISE: begin
                if (err)        nx = ST_ERRORS;
                else if (bch)   nx = ST_DECODE;
                else            nx = ST_FINISHED;
            end
            ST_ERRORS: begin
                if (bch)        nx = ST_DECODE;
                else            nx = ST_FINISHED;
            end
            default: nx = ST_FINISHED;
        endcase
        return nx;
    endfunction

    assign state_o = state_r;

    // Next-state decode; tcnt_r == 0 marks a stage's first cycle, whose done is ignored.
    always_comb begin
        state_nx_s   = state_r;
        accept_s     = 1'b0;
        stage_done_s = 1'b0;
        case (state_r)
            ST_ENCODE: stage_done_s = enc_done;
            ST_NOISE:  stage_done_s = noise_done;
            ST_ERRORS: stage_done_s = err_done;
            ST_DECODE: stage_done_s = dec_done;
            default:   stage_done_s = 1'b0;
        endcase
        timeout_s = (tcnt_r == TO_LAST);
        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        accept_s   = 1'b1;
                        state_nx_s = next_stage(ST_IDLE, cfg_bch_en, cfg_noise_en, cfg_err_en);
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ENCODE, ST_NOISE, ST_ERRORS, ST_DECODE: begin
                    if (stage_done_s && (tcnt_r != CNT_ZERO)) begin
                        state_nx_s = next_stage(state_r, bch_en_r, noise_en_r, err_en_r);
                    end else if (timeout_s) begin
                        state_nx_s = ST_FAULT;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State, counters, config latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            tcnt_r       <= CNT_ZERO;
            bch_en_r     <= 1'b0;
            noise_en_r   <= 1'b0;
            err_en_r     <= 1'b0;
            err_count    <= 8'd0;
            enc_start    <= 1'b0;
            noise_start  <= 1'b0;
            err_start    <= 1'b0;
            dec_start    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
            fault_stage  <= 3'd0;
            frame_cycles <= CNT_ZERO;
        end else begin
            state_r     <= state_nx_s;
            tcnt_r      <= (state_nx_s != state_r) ? CNT_ZERO : tcnt_r + CNT_ONE;
            enc_start   <= (state_nx_s == ST_ENCODE) && (state_r != ST_ENCODE);
            noise_start <= (state_nx_s == ST_NOISE)  && (state_r != ST_NOISE);
            err_start   <= (state_nx_s == ST_ERRORS) && (state_r != ST_ERRORS);
            dec_start   <= (state_nx_s == ST_DECODE) && (state_r != ST_DECODE);
            busy        <= (state_nx_s != ST_IDLE);
            // done trails the FINISHED cycle by one register stage
            done        <= (state_r == ST_FINISHED) && !abort;
            if (accept_s) begin
                bch_en_r     <= cfg_bch_en;
                noise_en_r   <= cfg_noise_en;
                err_en_r     <= cfg_err_en;
                err_count    <= cfg_num_errors;
                fault        <= 1'b0;
                fault_stage  <= 3'd0;
                frame_cycles <= CNT_ZERO;
            end else begin
                if ((state_nx_s == ST_FAULT) && (state_r != ST_FAULT)) begin
                    fault       <= 1'b1;
                    fault_stage <= state_r;
                end
                if ((state_r != ST_IDLE) && (frame_cycles != CNT_MAX)) begin
                    frame_cycles <= frame_cycles + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bch_link_sequencer.sv
// Randomized scoreboard bench for bch_link_sequencer: a frame-level model predicts
// every start/done/fault event with its cycle, and a monitor compares what appears.
module tb_bch_link_sequencer;

    localparam int T      = 8;
    localparam int CW     = 4;
    localparam int FC_MAX = 15;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic          cfg_bch_en, cfg_noise_en, cfg_err_en;
    logic [7:0]    cfg_num_errors;
    logic          enc_start, enc_done, noise_start, noise_done;
    logic          err_start, err_done, dec_start, dec_done;
    logic [7:0]    err_count;
    logic          busy, done, fault;
    logic [2:0]    fault_stage, state_o;
    logic [CW-1:0] frame_cycles;

    bch_link_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_bch_en(cfg_bch_en), .cfg_noise_en(cfg_noise_en), .cfg_err_en(cfg_err_en),
        .cfg_num_errors(cfg_num_errors),
        .enc_start(enc_start), .enc_done(enc_done),
        .noise_start(noise_start), .noise_done(noise_done),
        .err_start(err_start), .err_count(err_count), .err_done(err_done),
        .dec_start(dec_start), .dec_done(dec_done),
        .busy(busy), .done(done), .fault(fault), .fault_stage(fault_stage),
        .state_o(state_o), .frame_cycles(frame_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int kind;   // 1..4 stage start (stage code), 5 done, 6 fault
        int cyc;
        int data;   // err_count for starts, frame_cycles for done, fault_stage for fault
    } ev_t;
    ev_t expq[$];

    int dly[4];
    int hang_stage = -1;
    bit spur_first = 1'b0;
    bit spur_other = 1'b0;
    int cd[4] = '{-1, -1, -1, -1};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > FC_MAX) ? FC_MAX : v;
    endfunction

    // Stage engines: done dly cycles after start, optional ignorable spurious dones.
    always @(negedge clk) begin
        logic [3:0] st, dn;
        st = {dec_start, err_start, noise_start, enc_start};
        dn = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (st[i]) begin
                cd[i] = (hang_stage == i) ? -1 : dly[i];
                if (spur_first) dn[i] = 1'b1;
            end else if (cd[i] > 0) begin
                cd[i] = cd[i] - 1;
                if (cd[i] == 0) begin
                    dn[i] = 1'b1;
                    cd[i] = -1;
                end
            end else if (spur_other && (int'(state_o) != i + 1) && ($urandom_range(3, 0) == 0)) begin
                dn[i] = 1'b1;
            end
        end
        {dec_done, err_done, noise_done, enc_done} = dn;
    end

    // Monitor: pops one expected event per observed DUT event.
    initial begin
        bit fault_q;
        int obs[$];
        ev_t e;
        fault_q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            obs.delete();
            if (enc_start)          obs.push_back(1);
            if (noise_start)        obs.push_back(2);
            if (err_start)          obs.push_back(3);
            if (dec_start)          obs.push_back(4);
            if (done)               obs.push_back(5);
            if (fault && !fault_q)  obs.push_back(6);
            fault_q = fault;
            chk("busy_vs_state", int'(busy), int'(state_o != 3'd0));
            foreach (obs[i]) begin
                if (expq.size() == 0) begin
                    chk("unexpected_event", obs[i], 0);
                end else begin
                    e = expq.pop_front();
                    chk("event_kind", obs[i], e.kind);
                    chk("event_cycle", cyc, e.cyc);
                    if (e.kind <= 4)      chk("err_count", int'(err_count), e.data);
                    else if (e.kind == 5) chk("frame_cycles_at_done", int'(frame_cycles), e.data);
                    else                  chk("fault_stage", int'(fault_stage), e.data);
                end
            end
        end
    end

    // bs_mode: 0 none, 1 random busy start, 2 start during DECODE
    // kill_mode: 0 none, 1 random abort, 2 abort inside ERRORS, 3 rst inside ENCODE, 4 random rst
    task automatic run_frame(input bit b, input bit n, input bit e, input int num,
                             input int bs_mode, input int kill_mode);
        int  seq[$];
        ev_t evs[$];
        ev_t ev;
        int  stc[4];
        int  k0, t, f, last_busy, kill_cyc, bs_cyc, end_cyc;
        bit  faulted, is_rst, exp_fault;
        int  exp_fs, exp_fc;
        @(negedge clk);
        cfg_bch_en = b; cfg_noise_en = n; cfg_err_en = e;
        cfg_num_errors = 8'(num);
        start = 1'b1;
        k0 = cyc + 1;
        if (b) seq.push_back(0);
        if (n) seq.push_back(1);
        if (e) seq.push_back(2);
        if (b) seq.push_back(3);
        t = k0; f = 0; faulted = 1'b0;
        stc = '{0, 0, 0, 0};
        for (int i = 0; i < seq.size() && !faulted; i++) begin
            stc[seq[i]] = t;
            ev.kind = seq[i] + 1; ev.cyc = t; ev.data = num & 255;
            evs.push_back(ev);
            if (hang_stage == seq[i]) begin
                f = t + T;
                faulted = 1'b1;
                ev.kind = 6; ev.cyc = f; ev.data = seq[i] + 1;
                evs.push_back(ev);
            end else begin
                t = t + dly[seq[i]] + 1;
            end
        end
        if (!faulted) begin
            ev.kind = 5; ev.cyc = t + 1; ev.data = sat(t - k0 + 1);
            evs.push_back(ev);
        end
        last_busy = faulted ? f : t;
        case (kill_mode)
            1, 4:    kill_cyc = $urandom_range(last_busy, k0);
            2:       kill_cyc = stc[2] + 1;
            3:       kill_cyc = stc[0] + 1;
            default: kill_cyc = 1 << 30;
        endcase
        is_rst = (kill_mode == 3) || (kill_mode == 4);
        case (bs_mode)
            1:       bs_cyc = $urandom_range(last_busy, k0);
            2:       bs_cyc = stc[3] + 1;
            default: bs_cyc = -1;
        endcase
        foreach (evs[i]) if (evs[i].cyc <= kill_cyc) expq.push_back(evs[i]);
        exp_fault = faulted && (f <= kill_cyc) && !is_rst;
        exp_fs    = exp_fault ? (hang_stage + 1) : 0;
        exp_fc    = is_rst ? 0 : sat(((last_busy < kill_cyc) ? last_busy : kill_cyc) - k0 + 1);
        end_cyc   = (kill_mode != 0) ? kill_cyc + 11 : last_busy + 3;
        while (cyc < end_cyc) begin
            @(negedge clk);
            start = (cyc == bs_cyc);
            abort = (kill_mode != 0) && !is_rst && (cyc == kill_cyc);
            rst   = is_rst && (cyc == kill_cyc);
            if (cyc == k0) begin
                chk("fault_cleared_by_start", int'(fault), 0);
                cfg_num_errors = 8'($urandom);
                {cfg_bch_en, cfg_noise_en, cfg_err_en} = 3'($urandom);
            end
            if ((kill_mode != 0) && (cyc == kill_cyc + 1)) begin
                chk("killed_busy", int'(busy), 0);
                chk("killed_state", int'(state_o), 0);
                if (is_rst) begin
                    chk("rst_outputs", int'({enc_start, noise_start, err_start, dec_start,
                                            done, fault, fault_stage, err_count, frame_cycles}), 0);
                end
            end
        end
        chk("end_busy", int'(busy), 0);
        chk("end_state", int'(state_o), 0);
        chk("end_fault", int'(fault), int'(exp_fault));
        chk("end_fault_stage", int'(fault_stage), exp_fs);
        chk("end_frame_cycles", int'(frame_cycles), exp_fc);
        chk("events_left", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int km, bm;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_bch_en = 1'b0; cfg_noise_en = 1'b0; cfg_err_en = 1'b0; cfg_num_errors = 8'd0;
        dly = '{3, 3, 3, 3};
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state_o), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_fault", int'({fault, fault_stage}), 0);
        chk("reset_counts", int'({err_count, frame_cycles}), 0);
        chk("reset_starts", int'({enc_start, noise_start, err_start, dec_start}), 0);
        rst = 1'b0;

        run_frame(1'b1, 1'b1, 1'b1, 5, 0, 0);        // full chain, saturating frame count
        run_frame(1'b1, 1'b0, 1'b0, 9, 0, 0);        // encode + decode only
        run_frame(1'b0, 1'b0, 1'b0, 3, 0, 0);        // nothing enabled
        hang_stage = 1;
        run_frame(1'b0, 1'b1, 1'b0, 0, 0, 0);        // noise stage times out
        hang_stage = -1;
        dly = '{3, 7, 3, 3};
        run_frame(1'b0, 1'b1, 1'b0, 0, 0, 0);        // done on the timeout cycle wins
        dly = '{3, 2, 5, 3};
        run_frame(1'b1, 1'b1, 1'b1, 7, 0, 2);        // abort inside ERRORS
        dly = '{3, 3, 3, 3};
        run_frame(1'b1, 1'b1, 1'b1, 11, 2, 0);       // start during DECODE, cfg churn
        run_frame(1'b1, 1'b1, 1'b1, 4, 0, 3);        // rst inside ENCODE
        spur_first = 1'b1;
        run_frame(1'b1, 1'b0, 1'b0, 6, 0, 0);        // done coincident with start ignored
        spur_first = 1'b0;

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_with_abort_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("start_with_abort_state", int'(state_o), 0);

        repeat (60) begin
            for (int i = 0; i < 4; i++) dly[i] = $urandom_range(7, 1);
            hang_stage = ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            spur_first = 1'($urandom);
            spur_other = 1'($urandom);
            km = $urandom_range(7, 0);
            km = (km == 6) ? 1 : ((km == 7) ? 4 : 0);
            bm = (km == 0) ? int'($urandom_range(1, 0)) : 0;
            run_frame(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(255, 0)), bm, km);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
